buffer_flipper: RTL and testbench
=================================

# buffer_flipper

Double-buffer flip controller for the display memory. It owns the two frame buffers. While the display scanner reads one buffer, the data loader writes the other. On the loader's `loaded` pulse, the controller schedules a buffer swap for the next scanner frame boundary. It drives the loader's `ready` input and the buffer-select lines of both memory ports.

## Interface
Parameters:
- `flip_width`, 8: width of the `flips` frame counter.
- `stale_frames`, 60: number of scanner frames without a new load before `stale` asserts. Used only when `FLIPPER_STALE_EN` is defined.

Ports (single clock; reset is synchronous and active-high):
- `clk`, input, 1: system clock. All logic is on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `loaded`, input, 1: one-cycle pulse from the loader meaning a frame is complete in the write buffer.
- `frame_end`, input, 1: one-cycle pulse from the scanner after the last row of a frame is displayed.
- `ready`, output, 1: write buffer may be written; goes to the loader.
- `wbuf`, output, 1: buffer index for the write port.
- `rbuf`, output, 1: buffer index for the read/scan port.
- `flips`, output, `flip_width`: count of completed swaps.
- `overrun`, output, 1: sticky error; a `loaded` pulse arrived while `ready` was 0.
- `stale`, output, 1: no new frame for `stale_frames` frames. Tied to 0 when the feature is compiled out.

## Operation
- All outputs are registered. `wbuf` is always `~rbuf`.
- Reset values: `rbuf`=0, `wbuf`=1, `ready`=1, `flips`=0, `overrun`=0, `stale`=0. The state is `S_LOAD`.
- `S_LOAD`: `ready`=1.
  - On `loaded`=1: go to `S_PEND` and set `ready` to 0.
  - On `frame_end` with no `loaded`: stay in `S_LOAD`. The stale logic counts this frame.
- `S_PEND`: `ready`=0, waiting for a frame boundary.
  - On `frame_end`=1: toggle `rbuf` and `wbuf`, increment `flips`, go to `S_SWAP`.
  - On `loaded`=1 in this state: set `overrun` to 1. No other effect.
- `S_SWAP`: lasts exactly one cycle with `ready`=0, so the memory mux settles before loading resumes.
  - Next state is `S_LOAD` with `ready`=1.
  - `loaded` in this state sets `overrun`.
  - `frame_end` in this state is ignored.
- `loaded` and `frame_end` arriving in the same cycle in `S_LOAD`: `loaded` wins and the state moves to `S_PEND`. That `frame_end` does not flip; the swap waits for the next `frame_end`. This guarantees a full frame period of settling.
- `flips` wraps modulo 2^`flip_width` with no saturation.
- `overrun` clears only on `rst`.
- Reset mid-operation: all state returns to reset values on the next edge. Any pending flip is discarded and `rbuf` returns to 0.
- Any illegal state encoding recovers to `S_LOAD` on the next edge, with outputs unchanged except `ready`, which is driven to 1.

## Timing
- `loaded` sampled high at edge N in `S_LOAD` → `ready`=0 after edge N.
- `frame_end` sampled high at edge M in `S_PEND`:
  - `rbuf`, `wbuf` and `flips` update after edge M.
  - `ready`=1 after edge M+1.
- Minimum `loaded`-to-`ready` turnaround is 3 cycles: `loaded`, then `frame_end` on the next cycle, then `S_SWAP`.
- The loader latches `ready` at the start of a row load. `ready` therefore never rises in the same cycle the buffer selects change.
- `stale` (when enabled) asserts after the edge that samples the `stale_frames`-th `frame_end` since the last swap or reset. It clears after the edge that performs the next swap.

## Configuration
- `FLIPPER_STALE_EN` defined:
  - A frame counter, width `$clog2(stale_frames+1)`, counts `frame_end` pulses seen in `S_LOAD`.
  - It saturates at `stale_frames` and `stale` is set when it gets there.
  - The counter and `stale` reset to 0 on each swap and on `rst`.
- `FLIPPER_STALE_EN` undefined: no counter is built and `stale` is a constant 0.

## Test plan
- Reset, then idle 10 cycles → `ready`=1, `rbuf`=0, `wbuf`=1, `flips`=0, `overrun`=0.
- `loaded` pulse, `frame_end` 5 cycles later → `ready` is 0 from the next cycle. `rbuf`=1 and `wbuf`=0 right after the `frame_end` edge. `flips`=1. `ready`=1 one cycle later.
- `loaded` and `frame_end` in the same cycle, second `frame_end` 20 cycles later → no swap on the first `frame_end`; swap on the second. `flips`=1.
- `loaded` pulse in `S_PEND` → `overrun`=1 and stays 1 across the later swap. `flips` increments only once.
- 257 load/swap cycles with `flip_width`=8 → `flips` wraps to 1. `rbuf` ends at 1.
- With `FLIPPER_STALE_EN` and `stale_frames`=3: three `frame_end` pulses, no `loaded` → `stale`=1 after the third. Then `loaded` plus `frame_end` → `stale`=0 after the swap edge. Also assert `rst` during `S_PEND` → pending swap dropped, `rbuf`=0.

Source files
------------

// File: rtl/buffer_flipper_if.sv
// Loader/scanner-facing signals of the double-buffer flip controller.
// master: loader/scanner side; slave: the flip controller.
interface buffer_flipper_if #(
    parameter int unsigned flip_width = 8
);
    logic                  loaded;
    logic                  frame_end;
    logic                  ready;
    logic                  wbuf;
    logic                  rbuf;
    logic [flip_width-1:0] flips;
    logic                  overrun;
    logic                  stale;

    modport master (
        output loaded, frame_end,
        input  ready, wbuf, rbuf, flips, overrun, stale
    );

    modport slave (
        input  loaded, frame_end,
        output ready, wbuf, rbuf, flips, overrun, stale
    );
endinterface

// File: rtl/buffer_flipper.sv
// Double-buffer flip controller: swaps read/write frame buffers on the frame boundary after a load.
// Optional stale-frame detector is built when FLIPPER_STALE_EN is defined.
module buffer_flipper #(
    parameter int unsigned flip_width   = 8,
    parameter int unsigned stale_frames = 60
) (
    input  logic            clk,
    input  logic            rst,
    buffer_flipper_if.slave bus
);
    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_PEND = 2'd1,
        S_SWAP = 2'd2
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic                  rbuf_q;
    logic                  rbuf_nxt;
    logic                  wbuf_q;
    logic                  ready_q;
    logic                  ready_nxt;
    logic                  overrun_q;
    logic                  overrun_nxt;
    logic [flip_width-1:0] flips_q;
    logic [flip_width-1:0] flips_nxt;
    logic                  swap_c;

    // Next-state and registered-output values
    always_comb begin
        state_nxt   = state;
        rbuf_nxt    = rbuf_q;
        flips_nxt   = flips_q;
        overrun_nxt = overrun_q;
        swap_c      = 1'b0;
        case (state)
            S_LOAD: begin
                if (bus.loaded) state_nxt = S_PEND;
            end
            S_PEND: begin
                if (bus.frame_end) begin
                    swap_c    = 1'b1;
                    state_nxt = S_SWAP;
                end
                if (bus.loaded) overrun_nxt = 1'b1;
            end
            S_SWAP: begin
                state_nxt = S_LOAD;
                if (bus.loaded) overrun_nxt = 1'b1;
            end
            default: state_nxt = S_LOAD;
        endcase
        if (swap_c) begin
            rbuf_nxt  = ~rbuf_q;
            flips_nxt = flips_q + flip_width'(1);
        end
        // Ready only in S_LOAD, so it can never rise on the cycle the selects change
        ready_nxt = (state_nxt == S_LOAD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_LOAD;
            rbuf_q    <= 1'b0;
            wbuf_q    <= 1'b1;
            ready_q   <= 1'b1;
            flips_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            rbuf_q    <= rbuf_nxt;
            wbuf_q    <= ~rbuf_nxt;
            ready_q   <= ready_nxt;
            flips_q   <= flips_nxt;
            overrun_q <= overrun_nxt;
        end
    end

    assign bus.rbuf    = rbuf_q;
    assign bus.wbuf    = wbuf_q;
    assign bus.ready   = ready_q;
    assign bus.flips   = flips_q;
    assign bus.overrun = overrun_q;

`ifdef FLIPPER_STALE_EN
    localparam int unsigned cnt_w = (stale_frames < 1) ? 1 : $clog2(stale_frames + 1);
    localparam logic [cnt_w-1:0] stale_lim = cnt_w'(stale_frames);

    logic [cnt_w-1:0] frame_cnt;
    logic [cnt_w-1:0] frame_cnt_nxt;
    logic             stale_q;

    // Frames displayed while idle in S_LOAD, saturating at the limit
    always_comb begin
        frame_cnt_nxt = frame_cnt;
        if (swap_c) begin
            frame_cnt_nxt = '0;
        end else if ((state == S_LOAD) && bus.frame_end && (frame_cnt != stale_lim)) begin
            frame_cnt_nxt = frame_cnt + cnt_w'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt <= '0;
            stale_q   <= 1'b0;
        end else begin
            frame_cnt <= frame_cnt_nxt;
            stale_q   <= (frame_cnt_nxt == stale_lim);
        end
    end

    assign bus.stale = stale_q;
`else
    // stale_frames only matters when the detector is built
    localparam bit stale_cfg_nz = (stale_frames != 0);
    assign bus.stale = stale_cfg_nz & 1'b0;
`endif
endmodule

// File: tb/tb_buffer_flipper.sv
// Self-checking bench for buffer_flipper: directed vectors plus a cycle-level reference model.
module tb_buffer_flipper;
    localparam int unsigned FW = 8;
    localparam int unsigned SF = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    buffer_flipper_if #(.flip_width(FW)) bus ();

    buffer_flipper #(.flip_width(FW), .stale_frames(SF)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;
    bit check_en   = 1'b0;

    // Reference model: pending/settle flags and plain counters
    int m_rbuf   = 0;
    int m_flips  = 0;
    int m_over   = 0;
    int m_pend   = 0;
    int m_settle = 0;
    int m_frames = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_rbuf = 0; m_flips = 0; m_over = 0;
            m_pend = 0; m_settle = 0; m_frames = 0;
        end else if (m_settle != 0) begin
            if (bus.loaded) m_over = 1;
            m_settle = 0;
        end else if (m_pend != 0) begin
            if (bus.loaded) m_over = 1;
            if (bus.frame_end) begin
                m_rbuf   = 1 - m_rbuf;
                m_flips  = (m_flips + 1) % (1 << FW);
                m_pend   = 0;
                m_settle = 1;
                m_frames = 0;
            end
        end else begin
            if (bus.frame_end && m_frames < int'(SF)) m_frames++;
            if (bus.loaded) m_pend = 1;
        end
    end

    function automatic int exp_stale();
`ifdef FLIPPER_STALE_EN
        return (m_frames >= int'(SF)) ? 1 : 0;
`else
        return 0;
`endif
    endfunction

    task automatic check(input string name, input int actual, input int expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, actual, expected);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (check_en) begin
            check("m_ready",   int'(bus.ready),   (m_pend == 0 && m_settle == 0) ? 1 : 0);
            check("m_rbuf",    int'(bus.rbuf),    m_rbuf);
            check("m_wbuf",    int'(bus.wbuf),    1 - m_rbuf);
            check("m_flips",   int'(bus.flips),   m_flips);
            check("m_overrun", int'(bus.overrun), m_over);
            check("m_stale",   int'(bus.stale),   exp_stale());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic l, input logic f);
        bus.loaded    = l;
        bus.frame_end = f;
        tick();
        bus.loaded    = 1'b0;
        bus.frame_end = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        bus.loaded    = 1'b0;
        bus.frame_end = 1'b0;
        #1;
        do_reset();
        check_en = 1'b1;

        // Idle after reset
        repeat (10) tick();
        check("rst_ready",   int'(bus.ready),   1);
        check("rst_rbuf",    int'(bus.rbuf),    0);
        check("rst_wbuf",    int'(bus.wbuf),    1);
        check("rst_flips",   int'(bus.flips),   0);
        check("rst_overrun", int'(bus.overrun), 0);

        // Load then frame_end five cycles later
        pulse(1'b1, 1'b0);
        check("ld_ready_low", int'(bus.ready), 0);
        repeat (4) tick();
        check("pend_ready_low", int'(bus.ready), 0);
        pulse(1'b0, 1'b1);
        check("swap_rbuf",  int'(bus.rbuf),  1);
        check("swap_wbuf",  int'(bus.wbuf),  0);
        check("swap_flips", int'(bus.flips), 1);
        check("swap_ready", int'(bus.ready), 0);
        tick();
        check("post_swap_ready", int'(bus.ready), 1);

        // Simultaneous loaded and frame_end: swap waits for the next boundary
        do_reset();
        pulse(1'b1, 1'b1);
        check("coinc_ready", int'(bus.ready), 0);
        check("coinc_rbuf",  int'(bus.rbuf),  0);
        repeat (19) tick();
        check("coinc_flips_wait", int'(bus.flips), 0);
        pulse(1'b0, 1'b1);
        check("coinc_rbuf_swap", int'(bus.rbuf),  1);
        check("coinc_flips",     int'(bus.flips), 1);

        // Overrun in S_PEND is sticky across the swap
        do_reset();
        pulse(1'b1, 1'b0);
        pulse(1'b1, 1'b0);
        check("ovr_set", int'(bus.overrun), 1);
        check("ovr_flips_pend", int'(bus.flips), 0);
        pulse(1'b0, 1'b1);
        repeat (3) tick();
        check("ovr_sticky", int'(bus.overrun), 1);
        check("ovr_flips",  int'(bus.flips),   1);

        // loaded during S_SWAP also flags overrun
        do_reset();
        pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b1);
        check("swap_st_ovr_before", int'(bus.overrun), 0);
        pulse(1'b1, 1'b0);
        check("swap_st_ovr",   int'(bus.overrun), 1);
        check("swap_st_ready", int'(bus.ready),   1);

        // Flip counter wraps after 257 swaps
        do_reset();
        for (int i = 0; i < 257; i++) begin
            pulse(1'b1, 1'b0);
            pulse(1'b0, 1'b1);
            tick();
        end
        check("wrap_flips", int'(bus.flips), 1);
        check("wrap_rbuf",  int'(bus.rbuf),  1);

        // Reset during S_PEND drops the pending swap
        do_reset();
        pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b1);
        tick();
        check("rp_rbuf_pre", int'(bus.rbuf), 1);
        pulse(1'b1, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rp_rbuf",  int'(bus.rbuf),  0);
        check("rp_ready", int'(bus.ready), 1);
        check("rp_flips", int'(bus.flips), 0);
        pulse(1'b0, 1'b1);
        check("rp_no_flip", int'(bus.flips), 0);

        // Stale detection after SF idle frames, cleared by the next swap
        do_reset();
        pulse(1'b0, 1'b1);
        pulse(1'b0, 1'b1);
        check("stale_early", int'(bus.stale), 0);
        pulse(1'b0, 1'b1);
`ifdef FLIPPER_STALE_EN
        check("stale_set", int'(bus.stale), 1);
`else
        check("stale_off", int'(bus.stale), 0);
`endif
        pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b1);
        check("stale_clr", int'(bus.stale), 0);
        check("stale_clr_flips", int'(bus.flips), 1);
        repeat (3) tick();

        check_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
